// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: stage bit indices,
// sequencer state encoding and the NOP constants loaded by cleared registers.
package pipe_ctrl_pkg;

   localparam int STG_PC  = 0;
   localparam int STG_IF  = 1;
   localparam int STG_ID  = 2;
   localparam int STG_EX  = 3;
   localparam int STG_WB  = 4;
   localparam int N_STG   = 5;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DROP  = 2'd1;
   localparam logic [1:0] ST_REDIR = 2'd2;

   localparam logic [31:0] NOP_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INS = 32'h0000_0013;

   typedef logic [N_STG-1:0] stage_vec_t;

   typedef struct packed {
      stage_vec_t stall;
      stage_vec_t clear;
   } ctrl_vec_t;

   function automatic ctrl_vec_t mk_ctrl(input stage_vec_t s, input stage_vec_t c);
      ctrl_vec_t v;
      v.stall = s;
      v.clear = c;
      return v;
   endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Stall-cycle and flush-event counter pair; wraps modulo 2^CNT_W and holds while
// the chip is not ready.
module pipe_perf_cnt
#(
   parameter int CNT_W = 32
)
(
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             stall_inc,
   input  logic             flush_inc,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [1:0]            inc_vec;
   logic [1:0][CNT_W-1:0] cnt_vec;

   assign inc_vec   = {flush_inc, stall_inc};
   assign stall_cnt = cnt_vec[0];
   assign flush_cnt = cnt_vec[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;
         always_ff @(posedge clk_in) begin
            if (!rst_in) begin
               cnt_reg <= '0;
            end else if (rdy_in && inc_vec[gi]) begin
               cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         assign cnt_vec[gi] = cnt_reg;
      end
   endgenerate

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer with wrong-path fetch drop and registered PC redirect.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
)
(
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rdy_in,
   input  logic            if_busy,
   input  logic            if_done,
   input  logic            id_stall_req,
   input  logic            mem_stall_req,
   input  logic            ex_jump,
   input  logic [PC_W-1:0] ex_jump_pc,
   output logic [4:0]      stall,
   output logic [4:0]      clear,
   output logic            pc_redirect,
`ifdef PIPE_PERF_CNT_EN
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_flush_cnt,
`endif
   output logic [PC_W-1:0] pc_redirect_addr
);

   logic [1:0]      state_reg, state_next;
   logic [PC_W-1:0] redir_pc_reg, redir_pc_next;
   ctrl_vec_t       ctl;
   logic            if_wait;
   logic            jump_accept;

   assign if_wait = if_busy & ~if_done;

   always_comb begin
      ctl           = mk_ctrl(5'b00000, 5'b00000);
      pc_redirect   = 1'b0;
      state_next    = state_reg;
      redir_pc_next = redir_pc_reg;
      jump_accept   = 1'b0;
      if (!rst_in) begin
         ctl = mk_ctrl(5'b00000, 5'b11111);
      end else if (!rdy_in) begin
         ctl = mk_ctrl(5'b11111, 5'b00000);
      end else begin
         case (state_reg)
            ST_RUN: begin
               // MEM freezes EX, so a jump seen under a MEM stall is re-presented later.
               if (mem_stall_req) begin
                  ctl = mk_ctrl(5'b01111, 5'b10000);
               end else if (ex_jump) begin
                  ctl           = mk_ctrl(5'b00001, 5'b00110);
                  redir_pc_next = ex_jump_pc;
                  state_next    = if_wait ? ST_DROP : ST_REDIR;
                  jump_accept   = 1'b1;
               end else if (id_stall_req) begin
                  ctl = mk_ctrl(5'b00011, 5'b00100);
               end else if (if_wait) begin
                  ctl = mk_ctrl(5'b00001, 5'b00010);
               end
            end
            ST_DROP: begin
               ctl.stall[STG_PC] = 1'b1;
               ctl.clear[STG_IF] = 1'b1;
               if (mem_stall_req) begin
                  ctl.stall[STG_EX:STG_IF] = 3'b111;
                  ctl.clear[STG_WB]        = 1'b1;
               end
               if (id_stall_req) begin
                  ctl.stall[STG_IF] = 1'b1;
                  ctl.clear[STG_ID] = 1'b1;
               end
               if (if_done) begin
                  state_next = ST_REDIR;
               end
            end
            ST_REDIR: begin
               if (mem_stall_req) begin
                  ctl = mk_ctrl(5'b01111, 5'b10010);
               end else begin
                  ctl.clear[STG_IF] = 1'b1;
                  pc_redirect       = 1'b1;
                  state_next        = ST_RUN;
               end
            end
            default: begin
               state_next = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_reg    <= ST_RUN;
         redir_pc_reg <= '0;
      end else if (rdy_in) begin
         state_reg    <= state_next;
         redir_pc_reg <= redir_pc_next;
      end
   end

   assign stall            = ctl.stall;
   assign clear            = ctl.clear;
   assign pc_redirect_addr = redir_pc_reg;

`ifdef PIPE_PERF_CNT_EN
   pipe_perf_cnt #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .stall_inc (ctl.stall[STG_PC]),
      .flush_inc (jump_accept),
      .stall_cnt (perf_stall_cnt),
      .flush_cnt (perf_flush_cnt)
   );
`else
   logic unused_ok;
   assign unused_ok = jump_accept;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus randomized bench for pipe_ctrl against a behavioural model that
// tracks "redirect owed" and "wrong-path fetch still outstanding" as plain flags.
module tb_pipe_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, if_busy, if_done, id_stall_req, mem_stall_req, ex_jump;
   logic [31:0] ex_jump_pc;
   logic [4:0]  stall, clear;
   logic        pc_redirect;
   logic [31:0] pc_redirect_addr;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   pipe_ctrl #(.PC_W(32), .CNT_W(32)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .rdy_in           (rdy_in),
      .if_busy          (if_busy),
      .if_done          (if_done),
      .id_stall_req     (id_stall_req),
      .mem_stall_req    (mem_stall_req),
      .ex_jump          (ex_jump),
      .ex_jump_pc       (ex_jump_pc),
      .stall            (stall),
      .clear            (clear),
      .pc_redirect      (pc_redirect),
`ifdef PIPE_PERF_CNT_EN
      .perf_stall_cnt   (perf_stall_cnt),
      .perf_flush_cnt   (perf_flush_cnt),
`endif
      .pc_redirect_addr (pc_redirect_addr)
   );

   always #5 clk_in = ~clk_in;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   // model: a taken jump leaves a redirect owed; if a fetch was in flight it must land first
   bit          m_owed, m_wrong_fetch;
   logic [31:0] m_target;
   int unsigned m_stall_cnt, m_flush_cnt;
   logic [4:0]  e_stall, e_clear;
   logic        e_redir;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_outputs();
      e_stall = 5'b00000; e_clear = 5'b00000; e_redir = 1'b0;
      if (!rst_in) begin
         e_clear = 5'b11111;
      end else if (!rdy_in) begin
         e_stall = 5'b11111;
      end else if (m_owed && m_wrong_fetch) begin
         e_stall = 5'b00001 | (mem_stall_req ? 5'b01110 : 5'b0) | (id_stall_req ? 5'b00010 : 5'b0);
         e_clear = 5'b00010 | (mem_stall_req ? 5'b10000 : 5'b0) | (id_stall_req ? 5'b00100 : 5'b0);
      end else if (m_owed) begin
         if (mem_stall_req) begin e_stall = 5'b01111; e_clear = 5'b10010; end
         else begin e_clear = 5'b00010; e_redir = 1'b1; end
      end else if (mem_stall_req) begin
         e_stall = 5'b01111; e_clear = 5'b10000;
      end else if (ex_jump) begin
         e_stall = 5'b00001; e_clear = 5'b00110;
      end else if (id_stall_req) begin
         e_stall = 5'b00011; e_clear = 5'b00100;
      end else if (if_busy && !if_done) begin
         e_stall = 5'b00001; e_clear = 5'b00010;
      end
   endtask

   // settle: compare mid-cycle against the model; tick: cross the edge and advance the model
   task automatic settle(input string tag);
      @(negedge clk_in);
      assert (!(m_owed && ex_jump)) else $error("stimulus drove ex_jump while a redirect is owed");
      model_outputs();
      $display("[%0t] %-10s rst=%b rdy=%b busy=%b done=%b id=%b mem=%b jmp=%b | stall=%b clear=%b redir=%b addr=%h",
               $time, tag, rst_in, rdy_in, if_busy, if_done, id_stall_req, mem_stall_req, ex_jump,
               stall, clear, pc_redirect, pc_redirect_addr);
      check({tag, "_stall"}, {27'b0, stall}, {27'b0, e_stall});
      check({tag, "_clear"}, {27'b0, clear}, {27'b0, e_clear});
      check({tag, "_redir"}, {31'b0, pc_redirect}, {31'b0, e_redir});
      check({tag, "_addr"}, pc_redirect_addr, m_target);
`ifdef PIPE_PERF_CNT_EN
      check({tag, "_pstall"}, perf_stall_cnt, m_stall_cnt);
      check({tag, "_pflush"}, perf_flush_cnt, m_flush_cnt);
`endif
   endtask

   task automatic tick();
      @(posedge clk_in);
      if (!rst_in) begin
         m_owed = 0; m_wrong_fetch = 0; m_target = '0; m_stall_cnt = 0; m_flush_cnt = 0;
      end else if (rdy_in) begin
         if (e_stall[0]) m_stall_cnt++;
         if (m_owed && m_wrong_fetch) begin
            if (if_done) m_wrong_fetch = 0;
         end else if (m_owed) begin
            if (!mem_stall_req) m_owed = 0;
         end else if (!mem_stall_req && ex_jump) begin
            m_owed = 1; m_wrong_fetch = if_busy && !if_done; m_target = ex_jump_pc; m_flush_cnt++;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      if_busy = 0; if_done = 0; id_stall_req = 0; mem_stall_req = 0; ex_jump = 0; ex_jump_pc = '0;
   endtask

   initial begin
      m_owed = 0; m_wrong_fetch = 0; m_target = '0; m_stall_cnt = 0; m_flush_cnt = 0;
      rst_in = 0; rdy_in = 1; idle_inputs();
      tick();

      // reset with random inputs
      for (int i = 0; i < 2; i++) begin
         {if_busy, if_done, id_stall_req, mem_stall_req, ex_jump} = 5'($urandom);
         rdy_in = 1'($urandom); ex_jump_pc = $urandom;
         settle("reset");
         check("reset_clear_k", {27'b0, clear}, 32'h1F);
         tick();
      end
      rst_in = 1; rdy_in = 1; idle_inputs();
      settle("release"); check("release_clear_k", {27'b0, clear}, 32'h0); tick();

      // priority: mem over jump over id, then jump accepted once mem drops
      mem_stall_req = 1; ex_jump = 1; id_stall_req = 1; ex_jump_pc = 32'hDEAD_BEE0;
      settle("prio"); check("prio_stall_k", {27'b0, stall}, 32'h0F); tick();
      mem_stall_req = 0;
      settle("prio_jmp"); check("prio_jmp_clear_k", {27'b0, clear}, 32'h06); tick();
      idle_inputs();
      settle("prio_rd"); check("prio_rd_k", {31'b0, pc_redirect}, 32'h1); tick();

      // jump with idle fetch
      ex_jump = 1; ex_jump_pc = 32'h0000_1234;
      settle("jidle"); tick();
      idle_inputs();
      settle("jidle_rd"); check("jidle_addr_k", pc_redirect_addr, 32'h1234); tick();
      settle("jidle_run"); check("jidle_run_k", {31'b0, pc_redirect}, 32'h0); tick();

      // jump with fetch in flight, rdy_in dropped mid-drop
      ex_jump = 1; ex_jump_pc = 32'h8000_0040; if_busy = 1;
      settle("jfly"); tick();
      ex_jump = 0;
      for (int i = 0; i < 3; i++) begin
         settle("drop"); check("drop_s0_k", {31'b0, stall[0]}, 32'h1); tick();
         if (i == 1) begin
            rdy_in = 0;
            settle("nrdy"); check("nrdy_stall_k", {27'b0, stall}, 32'h1F); tick();
            rdy_in = 1;
         end
      end
      if_done = 1;
      settle("done"); tick();
      idle_inputs();
      settle("done_rd"); check("done_rd_k", {31'b0, pc_redirect}, 32'h1); tick();
`ifdef PIPE_PERF_CNT_EN
      check("three_jumps_k", perf_flush_cnt, 32'd3);
`endif

      // redirect held off by a MEM stall
      ex_jump = 1; ex_jump_pc = 32'h0000_0800;
      settle("jmem"); tick();
      idle_inputs(); mem_stall_req = 1;
      for (int i = 0; i < 2; i++) begin
         settle("rmem"); check("rmem_clear_k", {27'b0, clear}, 32'h12); tick();
      end
      mem_stall_req = 0;
      settle("rmem_rd"); check("rmem_rd_k", {31'b0, pc_redirect}, 32'h1); tick();

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         rst_in        = ($urandom_range(0, 63) != 0);
         rdy_in        = ($urandom_range(0, 7) != 0);
         if_busy       = 1'($urandom_range(0, 1));
         if_done       = ($urandom_range(0, 3) == 0);
         id_stall_req  = ($urandom_range(0, 4) == 0);
         mem_stall_req = ($urandom_range(0, 4) == 0);
         ex_jump       = !m_owed && ($urandom_range(0, 2) == 0);
         ex_jump_pc    = $urandom;
         settle("rand");
         tick();
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
